regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised multi-read register file for the CPU datapath; next generation of the 4x8 regfile.
//  Adds generic width/depth, two async read ports, a separate write address, an optional hardwired-zero entry,
//  and a multi-cycle soft-clear sweep with a busy/done handshake. Sits between decode (read addrs) and writeback.
// PARAMETERS
//  DATA_W    8  width of each entry in bits
//  DEPTH     4  number of entries; power of two, >=2
//  ADDR_W    $clog2(DEPTH)  address width (derived; do not override)
//  ZERO_REG  0  1: entry 0 always reads 0 and ignores writes
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       synchronous, active-high reset
//  rd_addr_a  in   ADDR_W  read port A address
//  rd_data_a  out  DATA_W  read port A data (combinational)
//  rd_addr_b  in   ADDR_W  read port B address
//  rd_data_b  out  DATA_W  read port B data (combinational)
//  wr_en      in   1       write request
//  wr_addr    in   ADDR_W  write address
//  wr_data    in   DATA_W  write data
//  wr_ready   out  1       1 = write accepted this cycle (= !clr_busy)
//  clr_req    in   1       soft-clear request; sampled only in IDLE
//  clr_busy   out  1       1 while the clear sweep runs
//  clr_done   out  1       one-cycle pulse after the sweep finishes
// BEHAVIOUR
//  Reset: all entries 0, FSM IDLE, sweep ptr 0, clr_busy=0, clr_done=0, wr_ready=1. Reset wins over all inputs.
//  Reset mid-sweep aborts the sweep: IDLE, all entries 0, no clr_done pulse.
//  Reads: rd_data_x = entry[rd_addr_x], zero latency. ZERO_REG=1 and addr 0 -> 0.
//  Write: wr_en && wr_ready -> entry[wr_addr] <= wr_data at the posedge; visible on reads the next cycle.
//   ZERO_REG=1 and wr_addr==0 -> write dropped silently. wr_en while !wr_ready -> dropped, no stall or retry.
//  FSM states: IDLE, CLEAR.
//   IDLE: clr_req=1 -> CLEAR, ptr<=0. A write in the same cycle is performed and is then overwritten by the sweep.
//   CLEAR: each cycle entry[ptr] <= 0, ptr <= ptr+1. At ptr==DEPTH-1 the entry is written, next state is IDLE,
//     and clr_done <= 1 for one cycle. clr_busy=1 for exactly DEPTH cycles. clr_req during CLEAR is ignored.
//   clr_req held high after done -> a new sweep starts on the first IDLE cycle (clr_done and IDLE coincide).
//  clr_busy is decoded from the registered state; clr_done is a registered pulse; wr_ready = !clr_busy.
//  Reads stay live during a sweep and return a mix of cleared and old entries.
//  ptr width is ADDR_W; wrap is not reachable because the FSM exits at DEPTH-1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if wr_en && wr_ready && wr_addr==rd_addr_x (and the write is not dropped by ZERO_REG),
//   rd_data_x = wr_data in the same cycle (write-through forwarding). Applies to both ports independently.
//  Undefined: a read of the address being written returns the old value until the next cycle.
// STRUCTURE
//  Package regfile_pkg: rf_state_t enum {RF_IDLE, RF_CLEAR}, localparam RF_DATA_W_DEF=8, RF_DEPTH_DEF=4.
//  Sub-module regfile_clear_fsm: owns state, ptr, clr_busy, clr_done; outputs clr_we/clr_addr to the array.
//  Top: storage array, write mux (sweep write has priority), read muxes, optional bypass.
// TESTING
//  1 Reset then read all addrs on A and B -> all 0; wr_ready=1, clr_busy=0, clr_done=0.
//  2 Write 8'hA5 to addr 2, read A=2, B=2 next cycle -> both 8'hA5; other entries still 0.
//  3 ZERO_REG=1: write 8'hFF to addr 0 -> addr 0 reads 0; write to addr 1 -> reads 8'hFF.
//  4 Fill all entries 8'h11..8'h44, pulse clr_req -> clr_busy=1 for DEPTH cycles, 1-cycle clr_done, all entries 0;
//    wr_en 8'h77 to addr 3 mid-sweep -> wr_ready=0, addr 3 stays 0.
//  5 Reset asserted on cycle 2 of a sweep -> IDLE next cycle, no clr_done, all 0, wr_ready=1.
//  6 Same-cycle wr 8'h3C to addr 1 with rd_addr_a=1 -> 8'h3C if REGFILE_BYPASS_EN, else old value; 8'h3C next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the parametrised register
//               file and its soft-clear sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Default geometry of the register file
  localparam int RF_DATA_W_DEF = 8;
  localparam int RF_DEPTH_DEF  = 4;

  // Sweep controller states; explicit 1-bit encoding keeps the state flop narrow
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_fsm
// Description : Soft-clear sweep controller. On a request seen in IDLE it
//               walks every entry once, issuing one clear write per cycle,
//               then pulses clr_done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [0:0]        S_IDLE   = RF_IDLE;
  localparam logic [0:0]        S_CLEAR  = RF_CLEAR;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  // Next-state logic: requests are only honoured in IDLE; the sweep exits after the last entry
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any sweep in progress without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = done_q;
  assign clr_we   = clr_busy;
  assign clr_addr = ptr_q;

endmodule : regfile_clear_fsm
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param
// Description : Parametrised register file with two combinational read ports,
//               one write port, optional hardwired-zero entry 0 and a
//               multi-cycle soft-clear sweep with busy/done handshake.
//               Define REGFILE_BYPASS_EN to forward same-cycle write data to
//               a read port whose address matches the accepted write.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_fire;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ready = !clr_busy;

  // A write lands only when the port is ready and it does not target the hardwired zero entry
  assign wr_fire = wr_en && wr_ready && !((ZERO_REG != 0) && (wr_addr == '0));

  // Array update: the sweep write is applied last so it wins over a user write
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_fire) begin
      mem_d[wr_addr] = wr_data;
    end
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end
  end

  // Storage flops
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port A: zero-latency lookup, zero entry masked, optional write-through
  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
`endif
  end

  // Read port B: same behaviour as port A, independent address
  always_comb begin
    rd_data_b = mem_q[rd_addr_b];
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
`endif
  end

endmodule : regfile_param
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_param
// Description : Self-checking bench for regfile_param. Two instances share
//               all inputs: one plain (ZERO_REG=0), one with ZERO_REG=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

  logic       clk;
  logic       reset;
  logic [1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] wr_data;
  logic       wr_en, clr_req;

  logic [7:0] rd_data_a, rd_data_b;
  logic       wr_ready, clr_busy, clr_done;
  logic [7:0] z_rd_data_a, z_rd_data_b;
  logic       z_wr_ready, z_clr_busy, z_clr_done;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_param #(.DATA_W(8), .DEPTH(4), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_param #(.DATA_W(8), .DEPTH(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(z_wr_ready),
    .clr_req(clr_req), .clr_busy(z_clr_busy), .clr_done(z_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_za;
    logic [7:0] exp_zb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i);
      rd_addr_b = 2'(3 - i);
      #1;
      check({name, "_a"}, {24'h0, rd_data_a}, 32'h0);
      check({name, "_b"}, {24'h0, rd_data_b}, 32'h0);
      check({name, "_za"}, {24'h0, z_rd_data_a}, 32'h0);
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  int cnt;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;

    //            we    wa     wd     ra     rb     exp_a  exp_b  exp_za exp_zb
    vecs[0] = '{1'b1, 2'd2, 8'hA5, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 2'd1, 8'h5A, 2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 2'd3, 8'hC3, 2'd1, 2'd2, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
    vecs[4] = '{1'b1, 2'd2, 8'h0F, 2'd3, 2'd1, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h0F, 8'hC3, 8'h0F, 8'hC3};
    vecs[6] = '{1'b1, 2'd0, 8'hFF, 2'd1, 2'd2, 8'h5A, 8'h0F, 8'h5A, 8'h0F};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 8'hFF, 8'hC3, 8'h00, 8'hC3};
    vecs[8] = '{1'b1, 2'd1, 8'hFF, 2'd0, 2'd3, 8'hFF, 8'hC3, 8'h00, 8'hC3};
    vecs[9] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    // Reset state, with a write request asserted to show reset wins
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hEE;
    tick(); tick();
    wr_en = 1'b0;
    check("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    check("rst_clr_busy", {31'h0, clr_busy}, 32'h0);
    check("rst_clr_done", {31'h0, clr_done}, 32'h0);
    check_all_zero("rst_read");
    reset = 1'b0;
    tick();

    // Table-driven write/read vectors
    for (int i = 0; i < 10; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      #1;
      check($sformatf("vec%0d_a", i), {24'h0, rd_data_a}, {24'h0, vecs[i].exp_a});
      check($sformatf("vec%0d_b", i), {24'h0, rd_data_b}, {24'h0, vecs[i].exp_b});
      check($sformatf("vec%0d_za", i), {24'h0, z_rd_data_a}, {24'h0, vecs[i].exp_za});
      check($sformatf("vec%0d_zb", i), {24'h0, z_rd_data_b}, {24'h0, vecs[i].exp_zb});
      tick();
    end
    wr_en = 1'b0;

    // Soft-clear sweep with writes attempted mid-sweep
    write(2'd0, 8'h11); write(2'd1, 8'h22); write(2'd2, 8'h33); write(2'd3, 8'h44);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && clr_busy; i++) begin
      cnt++;
      check("sweep_done_low", {31'h0, clr_done}, 32'h0);
      if (i == 1) begin
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
        #1;
        check("sweep_wr_ready", {31'h0, wr_ready}, 32'h0);
      end
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77;
        rd_addr_a = 2'd0; rd_addr_b = 2'd3;
        #1;
        check("sweep_mix_a", {24'h0, rd_data_a}, 32'h00);
        check("sweep_mix_b", {24'h0, rd_data_b}, 32'h44);
      end
      tick();
      wr_en = 1'b0;
    end
    check("sweep_busy_cycles", cnt, 32'd4);
    check("sweep_done_pulse", {31'h0, clr_done}, 32'h1);
    check("sweep_idle_ready", {31'h0, wr_ready}, 32'h1);
    tick();
    check("sweep_done_clear", {31'h0, clr_done}, 32'h0);
    check_all_zero("sweep_read");

    // Held request restarts on the cycle the done pulse is seen
    clr_req = 1'b1;
    tick();
    cnt = 0;
    while (clr_busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("held_first_len", cnt, 32'd4);
    check("held_done", {31'h0, clr_done}, 32'h1);
    check("held_busy_at_done", {31'h0, clr_busy}, 32'h0);
    tick();
    clr_req = 1'b0;
    check("held_restart_busy", {31'h0, clr_busy}, 32'h1);
    check("held_restart_done", {31'h0, clr_done}, 32'h0);
    cnt = 0;
    while (!clr_done && cnt < 20) begin
      cnt++;
      tick();
    end
    check("held_second_end", {31'h0, clr_done}, 32'h1);
    tick();

    // Reset on cycle 2 of a sweep aborts it
    write(2'd1, 8'h22); write(2'd2, 8'h33);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'h0, clr_busy}, 32'h0);
    check("abort_done", {31'h0, clr_done}, 32'h0);
    check("abort_ready", {31'h0, wr_ready}, 32'h1);
    check_all_zero("abort_read");
    tick();
    check("abort_no_done", {31'h0, clr_done}, 32'h0);
    check("abort_still_idle", {31'h0, clr_busy}, 32'h0);

    // Same-cycle write and read of one address
    write(2'd1, 8'h55);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_a", {24'h0, rd_data_a}, 32'h3C);
`else
    check("same_cycle_a", {24'h0, rd_data_a}, 32'h55);
`endif
    check("same_cycle_b", {24'h0, rd_data_b}, 32'h00);
    tick();
    wr_en = 1'b0;
    #1;
    check("next_cycle_a", {24'h0, rd_data_a}, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_param
`default_nettype wire
